// File: rtl/ks_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready back-pressure.
// One register rank per prefix level; the whole pipe stalls as a unit.

module ks_addsub_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

module ks_addsub_pipe #(
  parameter  int WIDTH  = 8,
  localparam int LEVELS = $clog2(WIDTH),
  localparam int LAT    = LEVELS + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  logic                             advance;
  logic [LAT-1:0]                   vld_pipe;
  logic [WIDTH-1:0]                 b_eff, g_s0, p_s0;
  logic                             cin_eff;
  logic [LEVELS:0][WIDTH-1:0]       g_q, p_q;
  logic [LEVELS-1:0][WIDTH-1:0]     pg_q;
  logic [LEVELS:1][WIDTH-1:0]       g_nx;
  logic [LEVELS-1:1][WIDTH-1:0]     pg_nx;
  logic [WIDTH-1:0]                 pg_top_unused;
  logic [LEVELS:0]                  cin_q, as_q, bs_q;
  logic [WIDTH-1:0]                 sum_nx;
  logic                             ovf_nx;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[LAT-1];

  // Carry-in enters as a generate at bit -1, folded into bit 0.
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub | in_cin;
    p_s0    = in_a ^ b_eff;
    g_s0    = in_a & b_eff;
    g_s0[0] = g_s0[0] | (p_s0[0] & cin_eff);
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int SPAN = 1 << (l - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        if (l < LEVELS) begin : g_mid
          ks_addsub_cell u_cell (
            .g_hi(g_q[l-1][i]), .p_hi(pg_q[l-1][i]),
            .g_lo(g_q[l-1][i-SPAN]), .p_lo(pg_q[l-1][i-SPAN]),
            .g(g_nx[l][i]), .p(pg_nx[l][i])
          );
        end else begin : g_top
          // Group propagate is dead after the last level.
          ks_addsub_cell u_cell (
            .g_hi(g_q[l-1][i]), .p_hi(pg_q[l-1][i]),
            .g_lo(g_q[l-1][i-SPAN]), .p_lo(pg_q[l-1][i-SPAN]),
            .g(g_nx[l][i]), .p(pg_top_unused[i])
          );
        end
      end else begin : g_pass
        assign g_nx[l][i] = g_q[l-1][i];
        if (l < LEVELS) begin : g_pmid
          assign pg_nx[l][i] = pg_q[l-1][i];
        end else begin : g_ptop
          assign pg_top_unused[i] = pg_q[l-1][i];
        end
      end
    end
  end

  // Datapath needs no reset: validity lives in vld_pipe only.
  always_ff @(posedge clk) begin
    if (advance) begin
      g_q[0]   <= g_s0;
      pg_q[0]  <= p_s0;
      p_q[0]   <= p_s0;
      cin_q[0] <= cin_eff;
      as_q[0]  <= in_a[WIDTH-1];
      bs_q[0]  <= b_eff[WIDTH-1];
      for (int l = 1; l <= LEVELS; l++) begin
        g_q[l]   <= g_nx[l];
        p_q[l]   <= p_q[l-1];
        cin_q[l] <= cin_q[l-1];
        as_q[l]  <= as_q[l-1];
        bs_q[l]  <= bs_q[l-1];
      end
      for (int l = 1; l < LEVELS; l++) pg_q[l] <= pg_nx[l];
    end
  end

  // Carry into bit i is the full-prefix generate of bits i-1..0.
  assign sum_nx = p_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
  assign ovf_nx = (as_q[LEVELS] == bs_q[LEVELS]) && (sum_nx[WIDTH-1] != as_q[LEVELS]);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
      if (vld_pipe[LAT-2]) begin
        out_sum  <= sum_nx;
        out_cout <= g_q[LEVELS][WIDTH-1];
        out_ovf  <= ovf_nx;
        out_zero <= ~|sum_nx;
      end
    end
  end

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Scoreboard bench for ks_addsub_pipe at WIDTH 8 (directed), 4 (exhaustive), 32 (random).

module tb_ks_addsub_pipe;

  localparam int LAT8 = 5;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4, zero4;
  logic [3:0] a4, b4, sum4;
  logic       in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32, zero32;
  logic [31:0] a32, b32, sum32;

  ks_addsub_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_a(a8), .in_b(b8),
    .in_cin(cin8), .in_sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(sum8), .out_cout(cout8), .out_ovf(ovf8), .out_zero(zero8));

  ks_addsub_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_a(a4), .in_b(b4),
    .in_cin(cin4), .in_sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(sum4), .out_cout(cout4), .out_ovf(ovf4), .out_zero(zero4));

  ks_addsub_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
    .out_sum(sum32), .out_cout(cout32), .out_ovf(ovf32), .out_zero(zero32));

  int n_chk = 0;
  int n_pass = 0;
  int pops8 = 0, pops4 = 0, pops32 = 0;
  exp_t q8[$], q4[$], q32[$];
  exp_t e8, e4, e32;

  // Reference: integer sum for {cout,sum}, signed range test for overflow.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [63:0] mask, bx;
    logic [64:0] full;
    longint      one, sa, sb, res, lim;
    one  = 1;
    mask = (64'd1 << w) - 64'd1;
    bx   = sub ? (~b & mask) : (b & mask);
    full = {1'b0, a & mask} + {1'b0, bx} + 65'(sub | cin);
    e.sum  = full[63:0] & mask;
    e.cout = full[w];
    sa = longint'(a & mask);
    if (a[w-1]) sa = sa - (one << w);
    sb = longint'(b & mask);
    if (b[w-1]) sb = sb - (one << w);
    res = sub ? (sa - sb) : (sa + sb + longint'(cin));
    lim = one << (w - 1);
    e.ovf  = (res >= lim) || (res < -lim);
    e.zero = (e.sum == 64'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) q8.delete();
    else begin
      if (out_valid8 && out_ready8) begin
        n_chk++; pops8++;
        if (q8.size() == 0) $display("FAIL sb8 unexpected beat sum=%h", sum8);
        else begin
          e8 = q8.pop_front();
          if ({cout8, ovf8, zero8, sum8} !== {e8.cout, e8.ovf, e8.zero, e8.sum[7:0]})
            $display("FAIL sb8 got c/o/z/sum=%b%b%b/%h want %b%b%b/%h", cout8, ovf8, zero8, sum8,
                     e8.cout, e8.ovf, e8.zero, e8.sum[7:0]);
          else n_pass++;
        end
      end
      if (in_valid8 && in_ready8) q8.push_back(model(8, 64'(a8), 64'(b8), cin8, sub8));
    end
  end

  always @(negedge clk) begin
    if (rst) q4.delete();
    else begin
      if (out_valid4 && out_ready4) begin
        n_chk++; pops4++;
        if (q4.size() == 0) $display("FAIL sb4 unexpected beat sum=%h", sum4);
        else begin
          e4 = q4.pop_front();
          if ({cout4, ovf4, zero4, sum4} !== {e4.cout, e4.ovf, e4.zero, e4.sum[3:0]})
            $display("FAIL sb4 got c/o/z/sum=%b%b%b/%h want %b%b%b/%h", cout4, ovf4, zero4, sum4,
                     e4.cout, e4.ovf, e4.zero, e4.sum[3:0]);
          else n_pass++;
        end
      end
      if (in_valid4 && in_ready4) q4.push_back(model(4, 64'(a4), 64'(b4), cin4, sub4));
    end
  end

  always @(negedge clk) begin
    if (rst) q32.delete();
    else begin
      if (out_valid32 && out_ready32) begin
        n_chk++; pops32++;
        if (q32.size() == 0) $display("FAIL sb32 unexpected beat sum=%h", sum32);
        else begin
          e32 = q32.pop_front();
          if ({cout32, ovf32, zero32, sum32} !== {e32.cout, e32.ovf, e32.zero, e32.sum[31:0]})
            $display("FAIL sb32 got c/o/z/sum=%b%b%b/%h want %b%b%b/%h", cout32, ovf32, zero32, sum32,
                     e32.cout, e32.ovf, e32.zero, e32.sum[31:0]);
          else n_pass++;
        end
      end
      if (in_valid32 && in_ready32) q32.push_back(model(32, 64'(a32), 64'(b32), cin32, sub32));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rand8();
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid8 !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid8); else n_pass++;
    n_chk++; if ({cout8, ovf8, zero8, sum8} !== 11'd0)
      $display("FAIL rst_fields got %b%b%b/%h want 000/00", cout8, ovf8, zero8, sum8); else n_pass++;
    n_chk++; if (in_ready8 !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready8); else n_pass++;
    n_chk++; if ({out_valid4, out_valid32} !== 2'b00)
      $display("FAIL rst_other_valid got %b want 00", {out_valid4, out_valid32}); else n_pass++;
  endtask

  task automatic test_add_wrap();
    int lat;
    cyc();
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
    cyc();
    in_valid8 = 1'b0; lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid8) break;
      cyc(); lat++;
    end
    n_chk++; if (lat !== LAT8) $display("FAIL wrap_latency got %0d want %0d", lat, LAT8); else n_pass++;
    n_chk++; if ({sum8, cout8, ovf8, zero8} !== {8'h00, 3'b101})
      $display("FAIL wrap_fields got %h/%b%b%b want 00/101", sum8, cout8, ovf8, zero8); else n_pass++;
    cyc();
  endtask

  task automatic test_flags();
    int lat;
    cyc();
    in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; sub8 = 1'b0;
    cyc();
    a8 = 8'h05; b8 = 8'h07; cin8 = 1'b1; sub8 = 1'b1;
    cyc();
    in_valid8 = 1'b0; lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid8) break;
      cyc(); lat++;
    end
    n_chk++; if ({out_valid8, sum8, cout8, ovf8, zero8} !== {1'b1, 8'h80, 3'b010})
      $display("FAIL add_ovf got v%b %h/%b%b%b want v1 80/010", out_valid8, sum8, cout8, ovf8, zero8); else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++; if ({out_valid8, sum8, cout8, ovf8, zero8} !== {1'b1, 8'hFE, 3'b000})
      $display("FAIL sub_borrow got v%b %h/%b%b%b want v1 FE/000", out_valid8, sum8, cout8, ovf8, zero8); else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ov, want;
    ov = '0;
    cyc();
    for (int j = 0; j < 32; j++) begin
      in_valid8 = (j < 10);
      rand8();
      @(negedge clk);
      ov[j] = out_valid8;
      cyc();
    end
    in_valid8 = 1'b0;
    want = 32'h3FF << LAT8;
    n_chk++; if (ov !== want) $display("FAIL b2b_valid_train got %h want %h", ov, want); else n_pass++;
  endtask

  task automatic test_stall();
    int sent, p0, j;
    logic [10:0] snap;
    sent = 0; p0 = pops8; snap = '0;
    cyc();
    for (j = 0; j < 40; j++) begin
      out_ready8 = !(j >= 6 && j <= 8);
      in_valid8  = (sent < 12);
      rand8();
      @(negedge clk);
      if (j >= 6 && j <= 8) begin
        n_chk++; if ({out_valid8, in_ready8} !== 2'b10)
          $display("FAIL stall_ready c%0d got v%b r%b want v1 r0", j, out_valid8, in_ready8); else n_pass++;
        if (j == 6) snap = {cout8, ovf8, zero8, sum8};
        else begin
          n_chk++; if ({cout8, ovf8, zero8, sum8} !== snap)
            $display("FAIL stall_hold c%0d got %h want %h", j, {cout8, ovf8, zero8, sum8}, snap); else n_pass++;
        end
      end
      if (in_valid8 && in_ready8) sent++;
      cyc();
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    n_chk++; if (q8.size() != 0 || pops8 - p0 != 12)
      $display("FAIL stall_count got pops=%0d left=%0d want 12/0", pops8 - p0, q8.size()); else n_pass++;
  endtask

  task automatic test_bubbles();
    logic [4:0]  pat;
    logic [15:0] ov;
    pat = 5'b01101;
    ov = '0;
    cyc();
    for (int j = 0; j < 16; j++) begin
      in_valid8 = (j < 5) ? pat[j] : 1'b0;
      rand8();
      @(negedge clk);
      ov[j] = out_valid8;
      cyc();
    end
    in_valid8 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      n_chk++; if (ov[j+LAT8] !== pat[j])
        $display("FAIL bubble_%0d got %b want %b", j, ov[j+LAT8], pat[j]); else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    int lat, seen;
    seen = 0;
    cyc();
    for (int j = 0; j < 3; j++) begin
      in_valid8 = 1'b1; rand8();
      cyc();
    end
    in_valid8 = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (out_valid8) seen++;
      cyc();
    end
    n_chk++; if (seen != 0) $display("FAIL flush_valid got %0d beats want 0", seen); else n_pass++;
    in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0;
    cyc();
    in_valid8 = 1'b0; lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid8) break;
      cyc(); lat++;
    end
    n_chk++; if (lat !== LAT8 || sum8 !== 8'h46)
      $display("FAIL post_rst got lat=%0d sum=%h want %0d/46", lat, sum8, LAT8); else n_pass++;
    cyc();
  endtask

  task automatic test_exhaustive4();
    logic [9:0] v;
    int k;
    out_ready4 = 1'b1;
    cyc();
    for (int i = 0; i < 1024; i++) begin
      v = 10'(i);
      in_valid4 = 1'b1; {a4, b4, cin4, sub4} = v;
      cyc();
    end
    in_valid4 = 1'b0;
    k = 0;
    while (q4.size() != 0 && k < 50) begin cyc(); k++; end
    @(negedge clk);
    n_chk++; if (q4.size() != 0 || pops4 != 1024)
      $display("FAIL exh4_count got pops=%0d left=%0d want 1024/0", pops4, q4.size()); else n_pass++;
  endtask

  task automatic test_random32();
    int sent, k;
    sent = 0; k = 0;
    cyc();
    while (sent < 10000 && k < 60000) begin
      in_valid32  = ($urandom_range(3) != 0);
      out_ready32 = ($urandom_range(3) != 0);
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
      @(negedge clk);
      if (in_valid32 && in_ready32) sent++;
      cyc(); k++;
    end
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    k = 0;
    while (q32.size() != 0 && k < 50) begin cyc(); k++; end
    @(negedge clk);
    n_chk++; if (q32.size() != 0 || pops32 != 10000 || sent != 10000)
      $display("FAIL rnd32_count got sent=%0d pops=%0d left=%0d want 10000/10000/0", sent, pops32, q32.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    test_reset();
    test_add_wrap();
    test_flags();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_midflight();
    test_exhaustive4();
    test_random32();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ks_addsub_pipe.md
Name: ks_addsub_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor. Generalises the fixed 4-bit combinational adder to any power-of-two width, adds subtract mode, carry-in and status flags, and registers every prefix level.
- Provides a valid/ready stream interface with back-pressure. It is the arithmetic core for wider datapaths in the same tile.

Parameters:
- WIDTH, 8, operand/sum width; power of two, 4..64.
- LEVELS, clog2(WIDTH), number of prefix levels (derived, not overridable).
- LAT, LEVELS+2, pipeline latency in accepted-to-valid cycles (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; used in ADD only.
- in_sub  in  1  0=ADD (A+B+cin), 1=SUB (A-B; internal cin=1, B inverted, in_cin ignored).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB; in SUB, 1 = no borrow (A>=B unsigned).
- out_ovf  out  1  signed overflow, two's complement.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Reset: clock and reset are a single clk with rst synchronous, active-high.
  - All stage valid bits clear.
  - out_valid=0; out_sum, out_cout, out_ovf, out_zero = 0.
  - in_ready=1 in the first cycle after reset release.
- Pipeline stages:
  - Stage 0 registers g=A&B', p=A^B' (B' = B or ~B), effective cin, and sign bits a[MSB], b'[MSB].
  - Carry-in is folded in as generate at bit −1, i.e. g0' = g0 | (p0 & cin).
  - Stages 1..LEVELS each register one Kogge-Stone prefix level (span 1,2,4,...):
    - G_i = G_i | (P_i & G_{i-span}); P_i = P_i & P_{i-span}.
    - Bits i<span pass through unchanged.
  - Final stage registers:
    - sum = p ^ {carries, cin}
    - cout = G_{MSB}
    - ovf = (aMSB == b'MSB) && (sum[MSB] != aMSB)
    - zero = ~|sum
  - No ripple adder permitted anywhere; the logic depth per stage is one prefix cell.
- Handshake and stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - On advance, every stage shifts one step. Stage 0 valid <= in_valid & in_ready.
  - With !advance, every stage holds, including bubbles. Bubbles are not squeezed.
  - Output fields stay stable while out_valid && !out_ready.
  - Transfer on each side occurs only when valid && ready, in the same cycle.
- Latency and throughput:
  - A beat accepted at edge k appears with out_valid=1 after edge k+LAT-1, i.e. LAT cycles counting the accept cycle, when unstalled.
  - Throughput is one beat per cycle with out_ready held high.
  - Order is strictly preserved; no beat is dropped or duplicated.
- Boundary conditions:
  - Simultaneous output pop and input push in a full pipe is legal and sustains full rate.
  - in_valid low inserts a bubble that travels with the pipe.
  - in_* are sampled only when in_valid && in_ready; at other times their values are don't-care.
  - rst asserted mid-stream discards all in-flight beats on that edge. out_valid falls the next cycle, with no partial result.
  - rst has priority over advance.
- Width rules:
  - All arithmetic is unsigned modulo 2^WIDTH, plus the separate cout/ovf.
  - SUB result equals A + ~B + 1.

Test Plan:
- WIDTH=8, ADD A=0xFF B=0x01 cin=0, out_ready=1 → exactly 5 cycles later: sum=0x00, cout=1, ovf=0, zero=1.
- WIDTH=8, ADD A=0x7F B=0x00 cin=1 → sum=0x80, cout=0, ovf=1, zero=0. SUB A=0x05 B=0x07 (cin=1 ignored) → sum=0xFE, cout=0, ovf=0.
- WIDTH=8, stream of 10 back-to-back beats, out_ready=1 → 10 consecutive out_valid cycles in order. Then drop out_ready for 3 cycles mid-stream → in_ready=0 while the output is held, output fields stable, no loss or duplication after release.
- WIDTH=8, in_valid pattern 1,0,1,1,0 → outputs show the identical bubble pattern shifted by LAT.
- Reset mid-flight: 3 beats accepted, assert rst for 1 cycle → no out_valid for those beats. A new beat after reset emerges after LAT with the correct result.
- WIDTH=4 exhaustive (A,B,cin,sub = 1024 combos) and WIDTH=32 random 10k beats with random out_ready → each result matches the {cout,sum} integer reference, and ovf/zero match the signed/zero check.
